sonar_scheduler: RTL and testbench

Round-robin measurement scheduler for up to N ultrasonic rangers sharing one echo-timing datapath. For each enabled sensor in turn, it issues the trigger pulse, times the echo, converts the echo width to centimetres and emits one result per measurement. It then observes an inter-measurement holdoff so that stale echoes from the previous sensor are ignored. It sits between the sensor pins and the existing filter/display path, replacing the single-sensor controller/counter pair when more than one ranger is fitted.

---
 rtl/sonar_pkg.sv | 24 ++
 rtl/sonar_timebase.sv | 31 +++
 rtl/sonar_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_sonar_scheduler.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and constants for the multi-ranger sonar scheduler.
package sonar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_REPORT,
        ST_HOLDOFF
    } state_t;

    localparam int DEF_DIST_W    = 9;
    localparam int DEF_US_PER_CM = 58;

    // All-ones distance marks an invalid or overrange result.
    localparam logic [DEF_DIST_W-1:0] DIST_INVALID = '1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sonar_timebase.sv
// Microsecond prescaler. The restart input marks cycle 0 of a new interval,
// so every timed interval is an exact multiple of CYC_PER_US cycles.
module sonar_timebase #(
    parameter int CYC_PER_US = 100
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic us_tick
);

    localparam int PW = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam logic [PW-1:0] LAST = PW'(CYC_PER_US - 1);

    logic [PW-1:0] cnt;
    logic [PW-1:0] phase;

    assign phase   = restart ? '0 : cnt;
    assign us_tick = (phase == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (us_tick) begin
            cnt <= '0;
        end else begin
            cnt <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin scheduler sharing one echo timer between several ultrasonic
// rangers: trigger, time the echo, report centimetres, then hold off.
module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter int N_SENSORS  = 4,
    parameter int CYC_PER_US = 100,
    parameter int TRIG_US    = 10,
    parameter int US_PER_CM  = DEF_US_PER_CM,
    parameter int TIMEOUT_US = 25000,
    parameter int HOLDOFF_US = 60000,
    parameter int DIST_W     = DEF_DIST_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [N_SENSORS-1:0]         sensor_mask,
    input  logic [N_SENSORS-1:0]         echo_in,
    output logic [N_SENSORS-1:0]         trig_out,
    output logic                         res_valid,
    output logic [$clog2(N_SENSORS)-1:0] res_id,
    output logic [DIST_W-1:0]            res_dist,
    output logic                         res_timeout,
    output logic                         busy
);

    localparam int ID_W  = $clog2(N_SENSORS);
    localparam int CNT_W = $clog2(max2(TIMEOUT_US, HOLDOFF_US) + 1);
    localparam int CMU_W = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

    localparam logic [CNT_W-1:0]  TRIG_END    = CNT_W'(TRIG_US);
    localparam logic [CNT_W-1:0]  TIMEOUT_END = CNT_W'(TIMEOUT_US);
    localparam logic [CNT_W-1:0]  HOLDOFF_END = CNT_W'(HOLDOFF_US);
    localparam logic [CMU_W-1:0]  CMU_LAST    = CMU_W'(US_PER_CM - 1);
    localparam logic [DIST_W-1:0] DIST_ONES   = '1;
    localparam logic [DIST_W-1:0] CM_MAX      = {{(DIST_W-1){1'b1}}, 1'b0};

    state_t state;
    logic   entry;

    logic [ID_W-1:0]      ptr;
    logic [N_SENSORS-1:0] echo_meta;
    logic [N_SENSORS-1:0] echo_sync;
    logic                 echo_cur;

    logic                 us_tick;
    logic                 timed;
    logic [CNT_W-1:0]     us_cnt;
    logic [CNT_W-1:0]     us_now;
    logic [CNT_W-1:0]     us_after;

    logic [CMU_W-1:0]     cm_us;
    logic [CMU_W-1:0]     cm_us_now;
    logic [CMU_W-1:0]     cm_us_after;
    logic                 cm_step;
    logic [DIST_W-1:0]    cm_cnt;
    logic [DIST_W-1:0]    cm_now;
    logic [DIST_W-1:0]    cm_after;

    logic                 pick_found;
    logic [ID_W-1:0]      pick_id;
    logic [ID_W-1:0]      cand;

    sonar_timebase #(
        .CYC_PER_US (CYC_PER_US)
    ) u_timebase (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (entry),
        .us_tick (us_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            echo_meta <= '0;
            echo_sync <= '0;
        end else begin
            echo_meta <= echo_in;
            echo_sync <= echo_meta;
        end
    end

    assign echo_cur = echo_sync[ptr];

    // Counts read as zero on the first cycle of a state, and each cycle's
    // tick is already folded in, so a decision made now sees the full time.
    assign timed       = state inside {ST_TRIG, ST_WAIT_RISE, ST_MEASURE, ST_HOLDOFF};
    assign us_now      = entry ? '0 : us_cnt;
    assign us_after    = us_now + CNT_W'(us_tick);

    assign cm_us_now   = entry ? '0 : cm_us;
    assign cm_step     = us_tick && (cm_us_now == CMU_LAST);
    assign cm_us_after = cm_step ? '0 : cm_us_now + CMU_W'(us_tick);
    assign cm_now      = entry ? '0 : cm_cnt;
    assign cm_after    = (cm_step && (cm_now != CM_MAX)) ? cm_now + 1'b1 : cm_now;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            us_cnt <= '0;
            cm_us  <= '0;
            cm_cnt <= '0;
        end else begin
            us_cnt <= timed ? us_after : '0;
            cm_us  <= (state == ST_MEASURE) ? cm_us_after : '0;
            cm_cnt <= (state == ST_MEASURE) ? cm_after : '0;
        end
    end

    // Scan downward so the nearest set bit after the pointer wins.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = N_SENSORS; k >= 1; k--) begin
            cand = ID_W'((int'(ptr) + k) % N_SENSORS);
            if (sensor_mask[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            entry       <= 1'b0;
            ptr         <= ID_W'(N_SENSORS - 1);
            trig_out    <= '0;
            res_valid   <= 1'b0;
            res_id      <= '0;
            res_dist    <= '0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            entry     <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && (sensor_mask != '0)) begin
                        state <= ST_SELECT;
                        entry <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                ST_SELECT: begin
                    entry <= 1'b1;
                    if (pick_found) begin
                        ptr      <= pick_id;
                        res_id   <= pick_id;
                        trig_out <= {{(N_SENSORS-1){1'b0}}, 1'b1} << pick_id;
                        state    <= ST_TRIG;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                ST_TRIG: begin
                    if (us_after == TRIG_END) begin
                        trig_out <= '0;
                        state    <= ST_WAIT_RISE;
                        entry    <= 1'b1;
                    end
                end

                // A stale echo still high here counts as a rise.
                ST_WAIT_RISE: begin
                    if (echo_cur) begin
                        state <= ST_MEASURE;
                        entry <= 1'b1;
                    end else if (us_after == TIMEOUT_END) begin
                        state       <= ST_REPORT;
                        entry       <= 1'b1;
                        res_valid   <= 1'b1;
                        res_dist    <= DIST_ONES;
                        res_timeout <= 1'b1;
                    end
                end

                ST_MEASURE: begin
                    if (!echo_cur) begin
                        state       <= ST_REPORT;
                        entry       <= 1'b1;
                        res_valid   <= 1'b1;
                        res_dist    <= cm_after;
                        res_timeout <= 1'b0;
                    end else if (us_after == TIMEOUT_END) begin
                        state       <= ST_REPORT;
                        entry       <= 1'b1;
                        res_valid   <= 1'b1;
                        res_dist    <= DIST_ONES;
                        res_timeout <= 1'b1;
                    end
                end

                ST_REPORT: begin
                    state <= ST_HOLDOFF;
                    entry <= 1'b1;
                end

                // Enable is only consulted here, so a dropped enable never
                // cuts a measurement short.
                ST_HOLDOFF: begin
                    if (us_after == HOLDOFF_END) begin
                        entry <= 1'b1;
                        if (enable) begin
                            state <= ST_SELECT;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    entry    <= 1'b1;
                    trig_out <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with short timings (1 cycle per us).
`timescale 1ns/1ps
module tb_sonar_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] sensor_mask = 4'b0000;
    logic [3:0] echo_in = 4'b0000;
    logic [3:0] trig_out;
    logic       res_valid;
    logic [1:0] res_id;
    logic [8:0] res_dist;
    logic       res_timeout;
    logic       busy;

    int n_checks = 0;
    int n_fails = 0;
    int cyc = 0;
    int res_pulses = 0;
    int multi_hot_cycles = 0;

    sonar_scheduler #(
        .N_SENSORS  (4),
        .CYC_PER_US (1),
        .TRIG_US    (10),
        .US_PER_CM  (58),
        .TIMEOUT_US (1000),
        .HOLDOFF_US (100),
        .DIST_W     (9)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .sensor_mask (sensor_mask),
        .echo_in     (echo_in),
        .trig_out    (trig_out),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_dist    (res_dist),
        .res_timeout (res_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (res_valid) res_pulses = res_pulses + 1;
        if ($countones(trig_out) > 1) multi_hot_cycles = multi_hot_cycles + 1;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic wait_trig_rise(input int budget, output bit ok, output logic [3:0] val, output int at);
        ok = 1'b0;
        val = '0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (trig_out != 4'b0000) begin
                ok = 1'b1;
                val = trig_out;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_trig_fall(input int budget, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (trig_out == 4'b0000) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_res(input int budget, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        enable = 1'b0;
        sensor_mask = 4'b0000;
        echo_in = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({trig_out, res_valid, res_id, res_dist, res_timeout, busy} !== 18'd0) begin
            n_fails++;
            $display("[TB] FAIL reset_outputs: got %0h expected 0",
                     {trig_out, res_valid, res_id, res_dist, res_timeout, busy});
        end
        do_reset();
        enable = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, trig_out} !== 5'd0) begin
            n_fails++;
            $display("[TB] FAIL empty_mask_idle: got busy=%0b trig=%b expected busy=0 trig=0000", busy, trig_out);
        end
    endtask

    task automatic test_single();
        bit ok;
        logic [3:0] val;
        int rise_at, fall_at, efall, res_at, p0;
        do_reset();
        sensor_mask = 4'b0001;
        enable = 1'b1;
        wait_trig_rise(50, ok, val, rise_at);
        n_checks++;
        if (!ok || val !== 4'b0001) begin
            n_fails++;
            $display("[TB] FAIL single_trig_bits: got ok=%0b trig=%b expected trig=0001", ok, val);
        end
        wait_trig_fall(50, ok, fall_at);
        n_checks++;
        if (!ok || (fall_at - rise_at) != 10) begin
            n_fails++;
            $display("[TB] FAIL single_trig_width: got ok=%0b width=%0d expected 10", ok, fall_at - rise_at);
        end
        @(posedge clk);
        #1;
        p0 = res_pulses;
        echo_in[0] = 1'b1;
        repeat (580) @(posedge clk);
        #1;
        echo_in[0] = 1'b0;
        efall = cyc;
        wait_res(20, ok, res_at);
        n_checks++;
        if (!ok || (res_at - efall) != 3) begin
            n_fails++;
            $display("[TB] FAIL single_latency: got ok=%0b latency=%0d expected 3", ok, res_at - efall);
        end
        n_checks++;
        if ({res_id, res_dist, res_timeout} !== {2'd0, 9'd10, 1'b0}) begin
            n_fails++;
            $display("[TB] FAIL single_result: got id=%0d dist=%0d to=%0b expected id=0 dist=10 to=0",
                     res_id, res_dist, res_timeout);
        end
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (120) @(posedge clk);
        #1;
        n_checks++;
        if ((res_pulses - p0) != 1 || busy !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL single_once: got pulses=%0d busy=%0b expected pulses=1 busy=0",
                     res_pulses - p0, busy);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [3:0] val;
        int rise_at, fall_at, res_at, next_at;
        do_reset();
        sensor_mask = 4'b0001;
        enable = 1'b1;
        wait_trig_rise(50, ok, val, rise_at);
        wait_trig_fall(50, ok, fall_at);
        wait_res(1100, ok, res_at);
        n_checks++;
        if (!ok || (res_at - fall_at) != 1000) begin
            n_fails++;
            $display("[TB] FAIL timeout_time: got ok=%0b delay=%0d expected 1000", ok, res_at - fall_at);
        end
        n_checks++;
        if ({res_dist, res_timeout} !== {9'd511, 1'b1}) begin
            n_fails++;
            $display("[TB] FAIL timeout_result: got dist=%0d to=%0b expected dist=511 to=1", res_dist, res_timeout);
        end
        wait_trig_rise(200, ok, val, next_at);
        n_checks++;
        if (!ok || (next_at - res_at) != 102 || val !== 4'b0001) begin
            n_fails++;
            $display("[TB] FAIL timeout_next_trig: got ok=%0b gap=%0d trig=%b expected gap=102 trig=0001",
                     ok, next_at - res_at, val);
        end
        enable = 1'b0;
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [3:0] val;
        int rise_at, fall_at, res_at, h0;
        int exp_ids[4] = '{0, 1, 3, 0};
        do_reset();
        sensor_mask = 4'b1011;
        enable = 1'b1;
        h0 = multi_hot_cycles;
        for (int m = 0; m < 4; m++) begin
            wait_trig_rise(300, ok, val, rise_at);
            n_checks++;
            if (!ok || val !== (4'b0001 << exp_ids[m])) begin
                n_fails++;
                $display("[TB] FAIL rr_order[%0d]: got ok=%0b trig=%b expected sensor %0d", m, ok, val, exp_ids[m]);
            end
            wait_trig_fall(50, ok, fall_at);
            @(posedge clk);
            #1;
            echo_in[exp_ids[m]] = 1'b1;
            repeat (116) @(posedge clk);
            #1;
            echo_in = 4'b0000;
            wait_res(20, ok, res_at);
            n_checks++;
            if (!ok || {res_id, res_dist, res_timeout} !== {2'(exp_ids[m]), 9'd2, 1'b0}) begin
                n_fails++;
                $display("[TB] FAIL rr_result[%0d]: got ok=%0b id=%0d dist=%0d to=%0b expected id=%0d dist=2 to=0",
                         m, ok, res_id, res_dist, res_timeout, exp_ids[m]);
            end
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (multi_hot_cycles != h0) begin
            n_fails++;
            $display("[TB] FAIL rr_onehot: got %0d multi-hot cycles expected 0", multi_hot_cycles - h0);
        end
    endtask

    task automatic test_long_echo();
        bit ok;
        logic [3:0] val;
        int rise_at, fall_at, e0, res_at, p0;
        do_reset();
        sensor_mask = 4'b0001;
        enable = 1'b1;
        wait_trig_rise(50, ok, val, rise_at);
        wait_trig_fall(50, ok, fall_at);
        @(posedge clk);
        #1;
        echo_in[0] = 1'b1;
        e0 = cyc;
        wait_res(1200, ok, res_at);
        n_checks++;
        if (!ok || (res_at - e0) != 1003) begin
            n_fails++;
            $display("[TB] FAIL long_echo_time: got ok=%0b delay=%0d expected 1003", ok, res_at - e0);
        end
        n_checks++;
        if ({res_dist, res_timeout} !== {9'd511, 1'b1}) begin
            n_fails++;
            $display("[TB] FAIL long_echo_result: got dist=%0d to=%0b expected dist=511 to=1", res_dist, res_timeout);
        end
        @(posedge clk);
        #1;
        enable = 1'b0;
        p0 = res_pulses;
        repeat (150) @(posedge clk);
        #1;
        n_checks++;
        if (res_pulses != p0 || busy !== 1'b0 || echo_in[0] !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL long_echo_tail: got extra=%0d busy=%0b expected extra=0 busy=0",
                     res_pulses - p0, busy);
        end
        repeat (60) @(posedge clk);
        #1;
        echo_in = 4'b0000;
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [3:0] val;
        int rise_at, fall_at, res_at;
        do_reset();
        sensor_mask = 4'b0010;
        enable = 1'b1;
        wait_trig_rise(50, ok, val, rise_at);
        wait_trig_fall(50, ok, fall_at);
        @(posedge clk);
        #1;
        echo_in[1] = 1'b1;
        repeat (116) @(posedge clk);
        #1;
        echo_in = 4'b0000;
        wait_res(20, ok, res_at);
        n_checks++;
        if (!ok || {res_id, res_dist} !== {2'd1, 9'd2}) begin
            n_fails++;
            $display("[TB] FAIL rst_pre_result: got ok=%0b id=%0d dist=%0d expected id=1 dist=2", ok, res_id, res_dist);
        end
        wait_trig_rise(300, ok, val, rise_at);
        wait_trig_fall(50, ok, fall_at);
        @(posedge clk);
        #1;
        echo_in[1] = 1'b1;
        repeat (30) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({trig_out, res_valid, res_id, res_dist, res_timeout, busy} !== 18'd0) begin
            n_fails++;
            $display("[TB] FAIL rst_mid_measure: got %0h expected 0",
                     {trig_out, res_valid, res_id, res_dist, res_timeout, busy});
        end
        echo_in = 4'b0000;
        sensor_mask = 4'b1111;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_trig_rise(50, ok, val, rise_at);
        n_checks++;
        if (!ok || val !== 4'b0001) begin
            n_fails++;
            $display("[TB] FAIL rst_first_sensor: got ok=%0b trig=%b expected 0001", ok, val);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({trig_out, busy} !== 5'd0) begin
            n_fails++;
            $display("[TB] FAIL rst_mid_trig: got trig=%b busy=%0b expected trig=0000 busy=0", trig_out, busy);
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_enable_drop();
        bit ok;
        logic [3:0] val;
        int rise_at, fall_at, res_at, late_at;
        do_reset();
        sensor_mask = 4'b0001;
        enable = 1'b1;
        wait_trig_rise(50, ok, val, rise_at);
        wait_trig_fall(50, ok, fall_at);
        @(posedge clk);
        #1;
        echo_in[0] = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (66) @(posedge clk);
        #1;
        echo_in = 4'b0000;
        wait_res(20, ok, res_at);
        n_checks++;
        if (!ok || {res_id, res_dist, res_timeout} !== {2'd0, 9'd2, 1'b0}) begin
            n_fails++;
            $display("[TB] FAIL drop_result: got ok=%0b id=%0d dist=%0d to=%0b expected id=0 dist=2 to=0",
                     ok, res_id, res_dist, res_timeout);
        end
        repeat (100) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL drop_busy_holdoff: got %0b expected 1", busy);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL drop_busy_idle: got %0b expected 0", busy);
        end
        wait_trig_rise(300, ok, val, late_at);
        n_checks++;
        if (ok) begin
            n_fails++;
            $display("[TB] FAIL drop_no_trigger: got trig=%b expected none", val);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_round_robin();
        test_long_echo();
        test_reset_mid();
        test_enable_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
